// File: rtl/button_pkg.sv
// Shared definitions for the push-button decoder and the LED driver that displays its events:
// FSM state encoding, default timing at a 16 MHz clock, and timer sizing.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_LONG_HELD      = 3'd2,
        ST_WAIT_SECOND    = 3'd3,
        ST_SECOND_PRESSED = 3'd4
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16000;     // 1 ms
    localparam int DEF_LONG_CYCLES     = 8000000;   // 0.5 s
    localparam int DEF_DOUBLE_CYCLES   = 4000000;   // 0.25 s
    localparam int COUNT_W             = 6;

    // One spare bit above the largest terminal value so a saturating timer never aliases it.
    function automatic int timer_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Brings the raw active-low button pin into the clock domain and debounces it into a
// clean pressed/released level.
module btn_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level
);

    localparam int              DB_W    = timer_width(DEBOUNCE_CYCLES, 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_level;
    logic            w_pressed;

    // Flops reset to 1 so a released pin reads as released straight out of reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // The level flips only after an unbroken run of disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (w_pressed == r_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt <= '0;
            r_level  <= w_pressed;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/button_decoder.sv
// Classifies debounced button activity into short, long and double-click events,
// each reported as a one-cycle pulse, and keeps a wrapping 6-bit event count.
module button_decoder
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter int DOUBLE_CYCLES   = DEF_DOUBLE_CYCLES
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_btn_n,
    output logic               o_level,
    output logic               o_short,
    output logic               o_long,
    output logic               o_double,
    output logic [COUNT_W-1:0] o_count
);

    localparam int               TMR_W       = timer_width(LONG_CYCLES, DOUBLE_CYCLES);
    localparam logic [TMR_W-1:0] LONG_LAST   = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOUBLE_LAST = TMR_W'(DOUBLE_CYCLES - 1);

    logic               w_level;
    logic               r_level_d;
    logic               w_rise;
    logic               w_fall;
    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic               w_short_nxt;
    logic               w_long_nxt;
    logic               w_double_nxt;
    logic               r_short;
    logic               r_long;
    logic               r_double;
    logic [COUNT_W-1:0] r_count;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn_n(i_btn_n),
        .o_level(w_level)
    );

    assign w_rise = w_level & ~r_level_d;
    assign w_fall = ~w_level & r_level_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_level_d <= 1'b0;
            r_state   <= ST_IDLE;
        end else begin
            r_level_d <= w_level;
            r_state   <= w_state_nxt;
        end
    end

    // Shared timer: measures time spent in the current state, holding at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_timer <= '0;
        end else if (w_state_nxt != r_state) begin
            r_timer <= '0;
        end else if (r_timer != '1) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_nxt = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (w_fall) begin
                    w_state_nxt = ST_WAIT_SECOND;
                end else if (r_timer == LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (w_fall) w_state_nxt = ST_IDLE;
            end
            ST_WAIT_SECOND: begin
                // A press landing exactly as the window closes closes out the single
                // click and starts a fresh press rather than forming a double.
                if (r_timer == DOUBLE_LAST) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = w_rise ? ST_PRESSED : ST_IDLE;
                end else if (w_rise) begin
                    w_state_nxt = ST_SECOND_PRESSED;
                end
            end
            ST_SECOND_PRESSED: begin
                if (w_fall) begin
                    w_double_nxt = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
        end else begin
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_double <= w_double_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (r_short | r_long | r_double) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_level  = w_level;
    assign o_short  = r_short;
    assign o_long   = r_long;
    assign o_double = r_double;
    assign o_count  = r_count;

endmodule

// File: tb/tb_button_decoder.sv
// Bench for button_decoder: directed scenarios with literal expectations plus randomized
// press/release traffic, all checked each cycle against a deadline-based behavioural model.
module tb_button_decoder;

  localparam int DB = 4;
  localparam int LC = 20;
  localparam int DC = 10;

  localparam int M_IDLE   = 0;
  localparam int M_FIRST  = 1;
  localparam int M_LONG   = 2;
  localparam int M_WAIT   = 3;
  localparam int M_SECOND = 4;

  logic       i_clk;
  logic       i_rst;
  logic       i_btn_n;
  logic       o_level;
  logic       o_short;
  logic       o_long;
  logic       o_double;
  logic [5:0] o_count;

  button_decoder #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LC),
    .DOUBLE_CYCLES  (DC)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn_n (i_btn_n),
    .o_level (o_level),
    .o_short (o_short),
    .o_long  (o_long),
    .o_double(o_double),
    .o_count (o_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Model state: raw-pin history, run of disagreeing samples, and absolute edge deadlines.
  typedef struct {
    bit raw1;
    bit raw2;
    int run;
    bit lvl;
    bit lvl_d;
    int mode;
    int deadline;
    bit sh;
    bit lg;
    bit db;
    int cnt;
    int edge_n;
  } model_t;

  model_t mdl;

  function automatic model_t m_reset();
    model_t n;
    n.raw1 = 1'b1;  n.raw2 = 1'b1;  n.run = 0;
    n.lvl = 1'b0;   n.lvl_d = 1'b0; n.mode = M_IDLE; n.deadline = 0;
    n.sh = 1'b0;    n.lg = 1'b0;    n.db = 1'b0;     n.cnt = 0; n.edge_n = 0;
    return n;
  endfunction

  function automatic model_t m_step(model_t m, bit raw);
    model_t n = m;
    bit sp;
    bit rise;
    bit fall;
    n.edge_n = m.edge_n + 1;
    sp = !m.raw2;
    n.raw2 = m.raw1;
    n.raw1 = raw;
    if (sp != m.lvl) begin
      n.run = m.run + 1;
      if (n.run == DB) begin
        n.lvl = sp;
        n.run = 0;
      end
    end else begin
      n.run = 0;
    end
    rise = m.lvl && !m.lvl_d;
    fall = !m.lvl && m.lvl_d;
    n.lvl_d = m.lvl;
    n.cnt = (m.cnt + ((m.sh || m.lg || m.db) ? 1 : 0)) % 64;
    n.sh = 1'b0; n.lg = 1'b0; n.db = 1'b0;
    case (m.mode)
      M_IDLE: if (rise) begin
        n.mode = M_FIRST; n.deadline = n.edge_n + LC;
      end
      M_FIRST: begin
        if (fall) begin
          n.mode = M_WAIT; n.deadline = n.edge_n + DC;
        end else if (n.edge_n == m.deadline) begin
          n.lg = 1'b1; n.mode = M_LONG;
        end
      end
      M_LONG: if (fall) n.mode = M_IDLE;
      M_WAIT: begin
        if (n.edge_n == m.deadline) begin
          n.sh = 1'b1;
          if (rise) begin
            n.mode = M_FIRST; n.deadline = n.edge_n + LC;
          end else begin
            n.mode = M_IDLE;
          end
        end else if (rise) begin
          n.mode = M_SECOND;
        end
      end
      M_SECOND: if (fall) begin
        n.db = 1'b1; n.mode = M_IDLE;
      end
      default: n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) mdl <= m_reset();
    else       mdl <= m_step(mdl, i_btn_n);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int scyc     = 0;
  bit obs_lvl  = 1'b0;
  int n_rise = 0, n_short = 0, n_long = 0, n_double = 0;
  int rise_s = -1, fall_s = -1, short_s = -1, long_s = -1, dbl_s = -1;
  int b_rise, b_short, b_long, b_double;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at sample %0d: got %0d, expected %0d", name, scyc, act, exp);
    end
  endtask

  task automatic compare_all();
    scyc++;
    check("level",  {31'd0, o_level},  {31'd0, mdl.lvl});
    check("short",  {31'd0, o_short},  {31'd0, mdl.sh});
    check("long",   {31'd0, o_long},   {31'd0, mdl.lg});
    check("double", {31'd0, o_double}, {31'd0, mdl.db});
    check("count",  {26'd0, o_count},  mdl.cnt);
    if (o_level === 1'b1 && !obs_lvl) begin n_rise++; rise_s = scyc; end
    if (o_level === 1'b0 &&  obs_lvl) fall_s = scyc;
    if (o_short === 1'b1)  begin n_short++;  short_s = scyc; end
    if (o_long === 1'b1)   begin n_long++;   long_s = scyc;  end
    if (o_double === 1'b1) begin n_double++; dbl_s = scyc;   end
    obs_lvl = (o_level === 1'b1);
  endtask

  task automatic tick(input bit raw, input bit rst);
    @(posedge i_clk);
    #1;
    i_btn_n = raw;
    i_rst   = rst;
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic hold_pressed(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic hold_released(input int n);
    repeat (n) tick(1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    repeat (3) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
  endtask

  task automatic snap();
    b_rise = n_rise; b_short = n_short; b_long = n_long; b_double = n_double;
    rise_s = -1000; fall_s = -1000; short_s = -1000; long_s = -1000; dbl_s = -1000;
  endtask

  int gaps [3]    = '{9, 10, 11};
  int exp_sh [3]  = '{0, 2, 2};
  int exp_db [3]  = '{1, 0, 0};
  int exp_cnt [3] = '{1, 2, 2};

  initial begin
    int deassert_s;
    i_rst   = 1'b1;
    i_btn_n = 1'b1;

    // Reset state
    apply_reset();
    check("reset_level", {31'd0, o_level}, 32'd0);
    check("reset_count", {26'd0, o_count}, 32'd0);

    // Short glitch never reaches the debounced level
    snap();
    hold_released(3);
    hold_pressed(2);
    hold_released(12);
    check("glitch_rises", n_rise - b_rise, 0);
    check("glitch_pulses", (n_short - b_short) + (n_long - b_long) + (n_double - b_double), 0);
    check("glitch_count", {26'd0, o_count}, 32'd0);

    // Single short press
    apply_reset();
    snap();
    hold_released(3);
    hold_pressed(8);
    hold_released(20);
    check("short_pulses", n_short - b_short, 1);
    check("short_latency", short_s - fall_s, DC + 1);
    check("short_others", (n_long - b_long) + (n_double - b_double), 0);
    check("short_count", {26'd0, o_count}, 32'd1);

    // Long press
    apply_reset();
    snap();
    hold_released(3);
    hold_pressed(30);
    hold_released(20);
    check("long_pulses", n_long - b_long, 1);
    check("long_latency", long_s - rise_s, LC + 1);
    check("long_others", (n_short - b_short) + (n_double - b_double), 0);
    check("long_count", {26'd0, o_count}, 32'd1);

    // Short press followed by a double click
    apply_reset();
    snap();
    hold_released(3);
    hold_pressed(8);
    hold_released(20);
    hold_pressed(6);
    hold_released(5);
    hold_pressed(6);
    hold_released(20);
    check("dbl_shorts", n_short - b_short, 1);
    check("dbl_doubles", n_double - b_double, 1);
    check("dbl_latency", dbl_s - fall_s, 1);
    check("dbl_count", {26'd0, o_count}, 32'd2);

    // Second press landing just before, exactly at, and just after the window closes
    for (int g = 0; g < 3; g++) begin
      apply_reset();
      snap();
      hold_released(3);
      hold_pressed(8);
      hold_released(gaps[g]);
      hold_pressed(8);
      hold_released(25);
      check("window_shorts", n_short - b_short, exp_sh[g]);
      check("window_doubles", n_double - b_double, exp_db[g]);
      check("window_count", {26'd0, o_count}, exp_cnt[g]);
    end

    // 64 short presses wrap the counter
    apply_reset();
    snap();
    hold_released(3);
    for (int k = 0; k < 64; k++) begin
      hold_pressed(8);
      hold_released(20);
    end
    check("wrap_shorts", n_short - b_short, 64);
    check("wrap_count", {26'd0, o_count}, 32'd0);

    // Reset while a press is being timed, button held throughout
    apply_reset();
    snap();
    hold_released(3);
    hold_pressed(10);
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    deassert_s = scyc;
    hold_pressed(30);
    hold_released(20);
    check("rst_relevel", rise_s - deassert_s, 6);
    check("rst_long_latency", long_s - rise_s, LC + 1);
    check("rst_long_pulses", n_long - b_long, 1);
    check("rst_other_pulses", (n_short - b_short) + (n_double - b_double), 0);
    check("rst_count", {26'd0, o_count}, 32'd1);

    // Randomized traffic, biased toward the double-click window edges
    apply_reset();
    hold_released(3);
    for (int k = 0; k < 60; k++) begin
      int sel;
      int gap;
      hold_pressed($urandom_range(30, 1));
      sel = $urandom_range(3, 0);
      gap = (sel == 0) ? 9 : (sel == 1) ? 10 : (sel == 2) ? 11 : $urandom_range(25, 1);
      hold_released(gap);
    end
    hold_released(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
